// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester round-robin write arbiter for a shared storage register
module reg_write_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             busy,
    output logic             last_grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       owner_next;
    logic       grant;
    logic       owner_req;
    logic [WIDTH-1:0] write_data;

    // Request and data of whichever requester currently owns the register
    assign owner_req  = owner ? req1 : req0;
    assign write_data = owner ? d1 : d0;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and arbitration decision; clr in IDLE suppresses any grant
    always_comb begin
        state_next = state;
        owner_next = owner;
        grant      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!clr && (req0 || req1)) begin
                    grant      = 1'b1;
                    state_next = WRITE;
                    if (req0 && req1) begin
                        owner_next = ~last_grant;
                    end else begin
                        owner_next = req1;
                    end
                end
            end
            WRITE: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!owner_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs derived directly from state and stored word
    always_comb begin
        busy = (state != IDLE);
        notQ = ~Q;
    end

    // Datapath: stored word, owner, round-robin pointer and acks
    always_ff @(posedge clk) begin
        if (reset) begin
            Q          <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        Q <= '0;
                    end else if (grant) begin
                        owner      <= owner_next;
                        last_grant <= owner_next;
                    end
                end
                WRITE: begin
                    // Write and ack complete regardless of the owner's req level
                    Q <= write_data;
                    if (owner) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!owner_req) begin
                        ack0 <= 1'b0;
                        ack1 <= 1'b0;
                    end
                end
                default: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       req0;
    logic [3:0] d0;
    logic       req1;
    logic [3:0] d1;
    logic       ack0;
    logic       ack1;
    logic [3:0] Q;
    logic [3:0] notQ;
    logic       busy;
    logic       last_grant;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .req0       (req0),
        .d0         (d0),
        .req1       (req1),
        .d1         (d1),
        .ack0       (ack0),
        .ack1       (ack1),
        .Q          (Q),
        .notQ       (notQ),
        .busy       (busy),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic ea0,
                           input logic ea1, input logic eb, input logic elg);
        chk({tag, ".Q"}, {28'd0, Q}, {28'd0, eq});
        chk({tag, ".notQ"}, {28'd0, notQ}, {28'd0, ~eq});
        chk({tag, ".ack0"}, {31'd0, ack0}, {31'd0, ea0});
        chk({tag, ".ack1"}, {31'd0, ack1}, {31'd0, ea1});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        chk({tag, ".last_grant"}, {31'd0, last_grant}, {31'd0, elg});
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = 4'h0; d1 = 4'h0;
        #1;
        tick(); tick();
        chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        chk_all("idle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // single write from requester 0
        req0 = 1'b1; d0 = 4'hA;
        tick();
        chk_all("w0_grant", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("w0_write", 4'hA, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("w0_hold", 4'hA, 1'b1, 1'b0, 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        chk_all("w0_release", 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);

        // fresh reset so the first tie goes to requester 0
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk_all("reset2", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // tie: 0 first, then 1, then 0 again
        req0 = 1'b1; req1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
        tick();
        chk_all("tie_grant0", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("tie_write0", 4'h3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("tie_hold0", 4'h3, 1'b1, 1'b0, 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        chk_all("tie_rel0", 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("tie_grant1", 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
        req0 = 1'b1;
        tick();
        chk_all("tie_write1", 4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("tie_hold1", 4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
        req1 = 1'b0;
        tick();
        chk_all("tie_rel1", 4'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        req0 = 1'b0;
        tick();
        chk_all("idle_no_req", 4'hC, 1'b0, 1'b0, 1'b0, 1'b1);
        req0 = 1'b1; req1 = 1'b1; d0 = 4'hA;
        tick();
        chk_all("rr_grant0", 4'hC, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("rr_write0", 4'hA, 1'b1, 1'b0, 1'b1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk_all("rr_rel0", 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);

        // clr beats a pending request in IDLE
        clr = 1'b1; req1 = 1'b1; d1 = 4'h5;
        tick();
        chk_all("clr_idle", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("clr_idle2", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        chk_all("clr_grant1", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_all("clr_write1", 4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        clr = 1'b1;
        tick();
        chk_all("clr_release", 4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        clr = 1'b0; req1 = 1'b0;
        tick();
        chk_all("clr_rel1", 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);

        // one-cycle pulse on req1: write still completes
        req1 = 1'b1; d1 = 4'h6;
        tick();
        chk_all("pulse_grant", 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
        req1 = 1'b0;
        tick();
        chk_all("pulse_write", 4'h6, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("pulse_rel", 4'h6, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset in RELEASE abandons the transaction
        req0 = 1'b1; d0 = 4'h9;
        tick();
        tick();
        chk_all("rst_write", 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_all("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        chk_all("rst_regrant", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("rst_rewrite", 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        chk_all("rst_rel", 4'h9, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
